vita49_pkt_arb: RTL and testbench

// - Packet-granular round-robin arbiter sharing the single 64-bit S_AXIS input of vita49_assem between NUM_IN sample streams.
// - Grant locked from first beat to TLAST; packets never interleave.
// - Enforces a maximum packet length: oversize packets are truncated and their remainder discarded.
// - Sits between channel sources and vita49_assem; en_mask/counters connect to the AXI-Lite register file.

---
 rtl/vita49_pkt_arb_if.sv | 27 ++
 rtl/vita49_pkt_arb.sv | 117 +++++++++++
 tb/tb_vita49_pkt_arb.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vita49_pkt_arb_if.sv
// Stream bundle between the channel sources, the packet arbiter and vita49_assem.
// Inputs are flattened per source; the output is a single 64-bit AXI-Stream.
interface vita49_pkt_arb_if #(
  parameter int NUM_IN = 2
);
  logic [64*NUM_IN-1:0] S_AXIS_TDATA;
  logic [NUM_IN-1:0]    S_AXIS_TVALID;
  logic [NUM_IN-1:0]    S_AXIS_TLAST;
  logic [NUM_IN-1:0]    S_AXIS_TREADY;
  logic [63:0]          M_AXIS_TDATA;
  logic                 M_AXIS_TVALID;
  logic                 M_AXIS_TLAST;
  logic [7:0]           M_AXIS_TSTRB;
  logic                 M_AXIS_TREADY;

  // Arbiter side: consumes the sources, drives the assembler.
  modport slave (
    input  S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    output S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TSTRB
  );

  // Environment side: sources plus the downstream sink.
  modport master (
    output S_AXIS_TDATA, S_AXIS_TVALID, S_AXIS_TLAST, M_AXIS_TREADY,
    input  S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TSTRB
  );
endinterface

// File: rtl/vita49_pkt_arb.sv
// Packet-granular round-robin arbiter with max-length truncation in front of vita49_assem.
// Zero-latency passthrough once granted, one idle arbitration cycle per packet; downstream ready goes straight back to the winner.
module vita49_pkt_arb #(
  parameter int NUM_IN    = 2,
  parameter int MAX_BEATS = 512
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESETN,
  vita49_pkt_arb_if.slave   axis,
  input  logic [NUM_IN-1:0] en_mask,
  output logic [2:0]        grant,
  output logic              busy,
  output logic [31:0]       pkt_cnt,
  output logic [31:0]       trunc_cnt
);
  localparam int GW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int BW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

  typedef enum logic [1:0] {IDLE, PASS, DROP} state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   grant_q, grant_d, pick;
  logic [BW-1:0]   beat_q, beat_d;
  logic [31:0]     pkt_q, pkt_d, trunc_q, trunc_d;
  logic            found;
  logic [NUM_IN-1:0] req, s_tready;
  logic [63:0]     m_tdata, g_dat;
  logic            m_tvalid, m_tlast, g_vld, g_last, at_max;

  assign req    = axis.S_AXIS_TVALID & en_mask;
  assign g_vld  = axis.S_AXIS_TVALID[grant_q];
  assign g_last = axis.S_AXIS_TLAST[grant_q];
  assign g_dat  = axis.S_AXIS_TDATA[64*int'(grant_q) +: 64];
  assign at_max = (beat_q == BW'(MAX_BEATS - 1));

  // Scan starts one past the last winner so every enabled source gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = grant_q;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!found && req[(int'(grant_q) + k) % NUM_IN]) begin
        found = 1'b1;
        pick  = GW'((int'(grant_q) + k) % NUM_IN);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    beat_d   = beat_q;
    pkt_d    = pkt_q;
    trunc_d  = trunc_q;
    s_tready = '0;
    m_tdata  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = PASS;
        end
      end
      PASS: begin
        m_tdata           = g_dat;
        m_tvalid          = g_vld;
        m_tlast           = g_last | at_max;
        s_tready[grant_q] = axis.M_AXIS_TREADY;
        if (g_vld && axis.M_AXIS_TREADY) begin
          beat_d = beat_q + BW'(1);
          // A natural TLAST on the limit beat is a clean finish, not a truncation.
          if (g_last) begin
            pkt_d   = pkt_q + 32'd1;
            state_d = IDLE;
          end else if (at_max) begin
            pkt_d   = pkt_q + 32'd1;
            if (trunc_q != '1) trunc_d = trunc_q + 32'd1;
            state_d = DROP;
          end
        end
      end
      DROP: begin
        s_tready[grant_q] = 1'b1;
        if (g_vld && g_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      state_q <= IDLE;
      grant_q <= GW'(NUM_IN - 1);
      beat_q  <= '0;
      pkt_q   <= '0;
      trunc_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      beat_q  <= beat_d;
      pkt_q   <= pkt_d;
      trunc_q <= trunc_d;
    end
  end

  assign axis.S_AXIS_TREADY = s_tready;
  assign axis.M_AXIS_TDATA  = m_tdata;
  assign axis.M_AXIS_TVALID = m_tvalid;
  assign axis.M_AXIS_TLAST  = m_tlast;
  assign axis.M_AXIS_TSTRB  = 8'hFF;
  assign grant              = 3'(grant_q);
  assign busy               = (state_q != IDLE);
  assign pkt_cnt            = pkt_q;
  assign trunc_cnt          = trunc_q;
endmodule

// File: tb/tb_vita49_pkt_arb.sv
// Randomised scoreboard bench for vita49_pkt_arb: sources tag each beat with their index,
// a packet-level model queues the expected output beats per source, a monitor pops and compares.
`timescale 1ns/1ps
module tb_vita49_pkt_arb;
  localparam int NI = 2;
  localparam int MB = 4;

  typedef struct packed {
    logic        l;
    logic [63:0] d;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NI-1:0] en;
  logic [2:0]    grant;
  logic          busy;
  logic [31:0]   pkt_cnt, trunc_cnt;

  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  pkt_seq = 0;
  int  exp_pkt = 0;
  int  exp_trunc = 0;
  bit  mon_en = 1'b1;
  bit  stuck0 = 1'b0;
  bit  ever_rdy0 = 1'b0;
  beat_t exp_q[NI][$];
  int    order_q[$];
  int    first_cyc_q[$];

  vita49_pkt_arb_if #(.NUM_IN(NI)) axis ();

  vita49_pkt_arb #(.NUM_IN(NI), .MAX_BEATS(MB)) dut (
    .AXIS_ACLK   (clk),
    .AXIS_ARESETN(rst_n),
    .axis        (axis),
    .en_mask     (en),
    .grant       (grant),
    .busy        (busy),
    .pkt_cnt     (pkt_cnt),
    .trunc_cnt   (trunc_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: routes every output beat by its source tag to that source's expected queue.
  initial begin : monitor
    bit    in_pkt;
    int    cur_src;
    int    src;
    beat_t e;
    in_pkt  = 1'b0;
    cur_src = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_pkt = 1'b0;
      end else begin
        if (axis.S_AXIS_TREADY[0]) ever_rdy0 = 1'b1;
        if (mon_en && axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
          src = int'(axis.M_AXIS_TDATA[63:60]);
          if (src >= NI) begin
            n_cmp++;
            n_bad++;
            $display("FAIL src_tag: got %0d expected below %0d", src, NI);
          end else begin
            if (in_pkt) chk("no_interleave", 65'(src), 65'(cur_src));
            else begin
              order_q.push_back(src);
              first_cyc_q.push_back(cyc);
            end
            chk("grant_vs_src", 65'(grant), 65'(src));
            if (exp_q[src].size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_beat: got %0h from input %0d expected none", axis.M_AXIS_TDATA, src);
            end else begin
              e = exp_q[src].pop_front();
              chk("beat", {axis.M_AXIS_TLAST, axis.M_AXIS_TDATA}, e);
            end
            in_pkt  = !axis.M_AXIS_TLAST;
            cur_src = src;
          end
        end
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < NI; i++) exp_q[i].delete();
    order_q.delete();
    first_cyc_q.delete();
    exp_pkt   = 0;
    exp_trunc = 0;
    ever_rdy0 = 1'b0;
  endtask

  task automatic do_reset();
    rst_n              = 1'b0;
    axis.S_AXIS_TVALID = '0;
    axis.S_AXIS_TLAST  = '0;
    axis.S_AXIS_TDATA  = '0;
    axis.M_AXIS_TREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear_model();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Sources: n0/n1 packets, fixed length (or random 1..7 when fixlen==0), percent valid / ready.
  task automatic run(input int n0, input int n1, input int fixlen, input int vld_pct,
                     input int rdy_pct, input int budget);
    int          left[NI];
    int          len[NI];
    int          bt[NI];
    bit          act[NI];
    bit          hs[NI];
    logic [63:0] pd[NI][8];
    beat_t       nb;
    int          kept;
    int          t;
    bit          done;
    left[0] = n0;
    left[1] = n1;
    for (int i = 0; i < NI; i++) begin
      len[i] = 0;
      bt[i]  = 0;
      act[i] = 1'b0;
    end
    t    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) hs[i] = axis.S_AXIS_TVALID[i] && axis.S_AXIS_TREADY[i];
      @(posedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        if (stuck0 && i == 0) begin
          axis.S_AXIS_TVALID[0]    = 1'b1;
          axis.S_AXIS_TLAST[0]     = 1'b1;
          axis.S_AXIS_TDATA[63:0]  = 64'h0BAD_0000_DEAD_BEEF;
        end else begin
          if (hs[i]) begin
            bt[i]++;
            if (bt[i] == len[i]) act[i] = 1'b0;
          end
          if (!act[i] && left[i] > 0) begin
            len[i] = (fixlen > 0) ? fixlen : int'($urandom_range(7, 1));
            for (int b = 0; b < len[i]; b++)
              pd[i][b] = {4'(i), 12'(pkt_seq), 16'(b), 32'($urandom)};
            kept = (len[i] > MB) ? MB : len[i];
            for (int b = 0; b < kept; b++) begin
              nb.l = (b == kept - 1);
              nb.d = pd[i][b];
              exp_q[i].push_back(nb);
            end
            exp_pkt++;
            if (len[i] > MB) exp_trunc++;
            pkt_seq++;
            left[i]--;
            bt[i]  = 0;
            act[i] = 1'b1;
          end
          if (act[i]) begin
            if (!(axis.S_AXIS_TVALID[i] && !hs[i]))
              axis.S_AXIS_TVALID[i] = ($urandom_range(99) < vld_pct);
            axis.S_AXIS_TDATA[64*i +: 64] = pd[i][bt[i]];
            axis.S_AXIS_TLAST[i]          = (bt[i] == len[i] - 1);
          end else begin
            axis.S_AXIS_TVALID[i] = 1'b0;
            axis.S_AXIS_TLAST[i]  = 1'b0;
          end
        end
      end
      axis.M_AXIS_TREADY = ($urandom_range(99) < rdy_pct);
      t++;
      done = 1'b1;
      for (int i = 0; i < NI; i++)
        if (left[i] > 0 || act[i] || exp_q[i].size() > 0) done = 1'b0;
      if (!done && t >= budget) begin
        n_cmp++;
        n_bad++;
        $display("FAIL timeout: got %0d cycles without draining expected %0d", t, budget);
        done = 1'b1;
      end
    end
    axis.S_AXIS_TVALID = '0;
    axis.S_AXIS_TLAST  = '0;
    axis.M_AXIS_TREADY = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    en                 = 2'b11;
    axis.S_AXIS_TVALID = '0;
    axis.S_AXIS_TLAST  = '0;
    axis.S_AXIS_TDATA  = '0;
    axis.M_AXIS_TREADY = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_tready", 65'(axis.S_AXIS_TREADY), 65'(0));
    chk("rst_m_tvalid", 65'(axis.M_AXIS_TVALID), 65'(0));
    chk("rst_m_tlast", 65'(axis.M_AXIS_TLAST), 65'(0));
    chk("rst_m_tdata", 65'(axis.M_AXIS_TDATA), 65'(0));
    chk("rst_busy", 65'(busy), 65'(0));
    chk("rst_grant", 65'(grant), 65'(NI - 1));
    chk("rst_pkt_cnt", 65'(pkt_cnt), 65'(0));
    chk("rst_trunc_cnt", 65'(trunc_cnt), 65'(0));
    chk("tstrb", 65'(axis.M_AXIS_TSTRB), 65'(8'hFF));

    // Round robin with both sources saturated: alternating order, 3 beats + 1 bubble apart.
    do_reset();
    run(3, 3, 3, 100, 100, 500);
    chk("rr_pkt_cnt", 65'(pkt_cnt), 65'(6));
    chk("rr_npkts", 65'(order_q.size()), 65'(6));
    for (int k = 0; k < order_q.size(); k++) chk("rr_order", 65'(order_q[k]), 65'(k % 2));
    for (int k = 1; k < first_cyc_q.size(); k++)
      chk("rr_spacing", 65'(first_cyc_q[k] - first_cyc_q[k-1]), 65'(4));

    // Masked source never gets ready even while valid.
    do_reset();
    en     = 2'b10;
    stuck0 = 1'b1;
    run(0, 2, 3, 100, 100, 500);
    chk("mask_grant", 65'(grant), 65'(1));
    chk("mask_in0_never_ready", 65'(ever_rdy0), 65'(0));
    chk("mask_pkt_cnt", 65'(pkt_cnt), 65'(2));
    stuck0 = 1'b0;
    en     = 2'b11;

    // Oversize packet truncated at MB beats, tail dropped.
    do_reset();
    run(1, 0, 7, 100, 100, 200);
    chk("trunc_trunc_cnt", 65'(trunc_cnt), 65'(1));
    chk("trunc_pkt_cnt", 65'(pkt_cnt), 65'(1));
    chk("trunc_busy_after", 65'(busy), 65'(0));

    // Exactly MB beats with natural TLAST is not a truncation.
    do_reset();
    run(1, 0, MB, 100, 100, 200);
    chk("exact_trunc_cnt", 65'(trunc_cnt), 65'(0));
    chk("exact_pkt_cnt", 65'(pkt_cnt), 65'(1));
    chk("exact_busy_after", 65'(busy), 65'(0));

    // Random lengths, source gaps and downstream stalls.
    do_reset();
    run(500, 500, 0, 70, 50, 60000);
    chk("rand_pkt_cnt", 65'(pkt_cnt), 65'(exp_pkt));
    chk("rand_trunc_cnt", 65'(trunc_cnt), 65'(exp_trunc));
    chk("rand_drained", 65'(exp_q[0].size() + exp_q[1].size()), 65'(0));

    // Reset in the middle of a packet aborts the output immediately.
    mon_en = 1'b0;
    axis.S_AXIS_TDATA[63:0] = 64'h0123_4567_89AB_CDEF;
    axis.S_AXIS_TVALID[0]   = 1'b1;
    axis.S_AXIS_TLAST[0]    = 1'b0;
    axis.M_AXIS_TREADY      = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    chk("midrst_busy_before", 65'(busy), 65'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_tready", 65'(axis.S_AXIS_TREADY), 65'(0));
    chk("midrst_m_tvalid", 65'(axis.M_AXIS_TVALID), 65'(0));
    chk("midrst_m_tlast", 65'(axis.M_AXIS_TLAST), 65'(0));
    do_reset();
    mon_en = 1'b1;
    chk("midrst_pkt_cnt", 65'(pkt_cnt), 65'(0));
    chk("midrst_trunc_cnt", 65'(trunc_cnt), 65'(0));
    chk("midrst_grant", 65'(grant), 65'(NI - 1));
    run(1, 1, 2, 100, 100, 200);
    chk("midrst_first_src", 65'((order_q.size() > 0) ? order_q[0] : 99), 65'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
